// File: rtl/clint_pkg.sv
// Shared constants, register-region enum and address helpers for the CLINT.
package clint_pkg;

  localparam logic [31:0] MsipBase     = 32'h0000_0000;
  localparam logic [31:0] MtimecmpBase = 32'h0000_4000;
  localparam logic [31:0] MtimeAddr    = 32'h0000_BFF8;
  localparam logic [31:0] SsipBase     = 32'h0000_C000;
  localparam int unsigned HartStride   = 8;

  localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    RegMsip,
    RegMtimecmp,
    RegMtime,
    RegSsip,
    RegNone
  } clint_reg_e;

  // True when addr falls on one of the first numHarts slots of a per-hart region.
  function automatic logic inRegion(logic [31:0] addr, logic [31:0] base, int unsigned numHarts);
    return (addr >= base) && (((addr - base) / HartStride) < numHarts);
  endfunction

  function automatic logic [3:0] hartOf(logic [31:0] addr, logic [31:0] base);
    return 4'((addr - base) / HartStride);
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: tick_o pulses once every CLOCK_CYCLES clocks.
module clint_tick_gen #(
  parameter int CLOCK_CYCLES = 30
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam int CntW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLOCK_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_comb begin
    tick_o  = (count_q == CntMax);
    count_d = tick_o ? '0 : count_q + CntW'(1);
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared mtime, per-hart msip/mtimecmp, Wishbone slave.
// Optional supervisor software interrupts (SSIP region at 0xC000) enabled by CLINT_SSWI_EN.
module clint_mh
  import clint_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int ADDR_SIZE    = 16,
  parameter int NUM_HARTS    = 4,
  parameter int CLOCK_CYCLES = 30
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_SIZE-1:0]    wb_adr_i,
  input  logic [DATA_SIZE-1:0]    wb_dat_i,
  output logic                    wb_ack_o,
  output logic [DATA_SIZE-1:0]    wb_dat_o,
  output logic [NUM_HARTS-1:0]    msip,
  output logic [NUM_HARTS-1:0]    mtip,
`ifdef CLINT_SSWI_EN
  output logic [NUM_HARTS-1:0]    ssip,
`endif
  output logic [63:0]             mtime,
  output logic [64*NUM_HARTS-1:0] mtimecmp_o
);

  logic                    tick;
  logic                    ack_q, ack_d;
  logic [DATA_SIZE-1:0]    dat_q, dat_d;
  logic [63:0]             mtime_q;
  logic [NUM_HARTS-1:0]    msip_q;
  logic [64*NUM_HARTS-1:0] mtimecmp_q;
`ifdef CLINT_SSWI_EN
  logic [NUM_HARTS-1:0]    ssip_q;
`endif

  logic        req, wrEn;
  logic [31:0] addr32;
  clint_reg_e  regSel;
  logic [3:0]  hartIdx;
  logic [63:0] oldVal, mergedVal, newVal;

  clint_tick_gen #(.CLOCK_CYCLES(CLOCK_CYCLES)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .tick_o (tick)
  );

  // The acked cycle never starts a new request, so a held request is served every other cycle.
  assign req    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wrEn   = req & wb_we_i;
  assign ack_d  = req;
  assign addr32 = 32'(wb_adr_i);

  always_comb begin
    regSel  = RegNone;
    hartIdx = '0;
    if (inRegion(addr32, MsipBase, NUM_HARTS)) begin
      regSel  = RegMsip;
      hartIdx = hartOf(addr32, MsipBase);
    end else if (inRegion(addr32, MtimecmpBase, NUM_HARTS)) begin
      regSel  = RegMtimecmp;
      hartIdx = hartOf(addr32, MtimecmpBase);
    end else if ((addr32 / HartStride) == (MtimeAddr / HartStride)) begin
      regSel  = RegMtime;
`ifdef CLINT_SSWI_EN
    end else if (inRegion(addr32, SsipBase, NUM_HARTS)) begin
      regSel  = RegSsip;
      hartIdx = hartOf(addr32, SsipBase);
`endif
    end
  end

  always_comb begin
    oldVal = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hartIdx == 4'(h)) begin
        if (regSel == RegMsip)     oldVal = {63'b0, msip_q[h]};
        if (regSel == RegMtimecmp) oldVal = mtimecmp_q[64*h +: 64];
`ifdef CLINT_SSWI_EN
        if (regSel == RegSsip)     oldVal = {63'b0, ssip_q[h]};
`endif
      end
    end
    if (regSel == RegMtime) oldVal = mtime_q;
  end

  // An MTIME write landing on a tick edge absorbs that tick, so the increment is folded in here.
  always_comb begin
    case (regSel)
      RegMsip, RegSsip: newVal = {63'b0, mergedVal[0]};
      RegMtimecmp:      newVal = mergedVal;
      RegMtime:         newVal = mergedVal + 64'(tick);
      default:          newVal = '0;
    endcase
  end

  if (DATA_SIZE == 64) begin : g_rv64
    assign mergedVal = wb_dat_i;
    assign dat_d     = req ? (wb_we_i ? newVal : oldVal) : '0;
  end else begin : g_rv32
    logic [63:0] retVal;
    assign mergedVal = wb_adr_i[2] ? {wb_dat_i, oldVal[31:0]} : {oldVal[63:32], wb_dat_i};
    assign retVal    = wb_we_i ? newVal : oldVal;
    assign dat_d     = !req ? '0 : (wb_adr_i[2] ? retVal[63:32] : retVal[31:0]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      msip_q     <= '0;
      mtimecmp_q <= {NUM_HARTS{MtimecmpReset}};
    end else begin
      if (wrEn && regSel == RegMtime) mtime_q <= newVal;
      else if (tick)                  mtime_q <= mtime_q + 64'd1;
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wrEn && hartIdx == 4'(h)) begin
          if (regSel == RegMsip)     msip_q[h]              <= newVal[0];
          if (regSel == RegMtimecmp) mtimecmp_q[64*h +: 64] <= newVal;
        end
      end
    end
  end

`ifdef CLINT_SSWI_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ssip_q <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wrEn && regSel == RegSsip && hartIdx == 4'(h)) ssip_q[h] <= newVal[0];
      end
    end
  end

  assign ssip = ssip_q;
`endif

  always_comb begin
    mtip = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtip[h] = (mtime_q >= mtimecmp_q[64*h +: 64]);
    end
  end

  assign msip       = msip_q;
  assign mtime      = mtime_q;
  assign mtimecmp_o = mtimecmp_q;
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_clint_mh.sv
// Directed bench for clint_mh: one RV64 and one RV32 instance sharing clock/reset, 4 harts, prescale 4.
module tb_clint_mh;

  localparam int Harts = 4;
  localparam int Cc    = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int edgeCnt   = 0;
  int passCnt   = 0;
  int totalCnt  = 0;

  logic        cyc64 = 0, stb64 = 0, we64 = 0;
  logic [15:0] adr64 = '0;
  logic [63:0] wdat64 = '0, rdat64;
  logic        ack64;
  logic [3:0]  msip64, mtip64;
  logic [63:0] mtime64;
  logic [255:0] cmp64;

  logic        cyc32 = 0, stb32 = 0, we32 = 0;
  logic [15:0] adr32 = '0;
  logic [31:0] wdat32 = '0, rdat32;
  logic        ack32;
  logic [3:0]  msip32, mtip32;
  logic [63:0] mtime32;
  logic [255:0] cmp32;
`ifdef CLINT_SSWI_EN
  logic [3:0]  ssip64, ssip32;
`endif

  clint_mh #(.DATA_SIZE(64), .ADDR_SIZE(16), .NUM_HARTS(Harts), .CLOCK_CYCLES(Cc)) dut64 (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc64), .wb_stb_i(stb64), .wb_we_i(we64), .wb_adr_i(adr64), .wb_dat_i(wdat64),
    .wb_ack_o(ack64), .wb_dat_o(rdat64),
    .msip(msip64), .mtip(mtip64),
`ifdef CLINT_SSWI_EN
    .ssip(ssip64),
`endif
    .mtime(mtime64), .mtimecmp_o(cmp64)
  );

  clint_mh #(.DATA_SIZE(32), .ADDR_SIZE(16), .NUM_HARTS(Harts), .CLOCK_CYCLES(Cc)) dut32 (
    .clock(clock), .reset(reset),
    .wb_cyc_i(cyc32), .wb_stb_i(stb32), .wb_we_i(we32), .wb_adr_i(adr32), .wb_dat_i(wdat32),
    .wb_ack_o(ack32), .wb_dat_o(rdat32),
    .msip(msip32), .mtip(mtip32),
`ifdef CLINT_SSWI_EN
    .ssip(ssip32),
`endif
    .mtime(mtime32), .mtimecmp_o(cmp32)
  );

  // Edges since reset release; tick edges are those with edgeCnt % Cc == 0.
  always @(posedge clock) begin
    if (reset) edgeCnt = 0;
    else       edgeCnt = edgeCnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Called at a negedge; request edge is the next posedge; returns at the negedge one cycle after ack.
  task automatic bus64(input logic we, input logic [15:0] adr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic ackOk);
    logic ackPre;
    cyc64 = 1; stb64 = 1; we64 = we; adr64 = adr; wdat64 = wd;
    ackPre = ack64;
    @(negedge clock);
    ackOk = ack64 && !ackPre;
    rd = rdat64;
    cyc64 = 0; stb64 = 0; we64 = 0;
    @(negedge clock);
    ackOk = ackOk && !ack64;
  endtask

  task automatic bus32(input logic we, input logic [15:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic ackOk);
    logic ackPre;
    cyc32 = 1; stb32 = 1; we32 = we; adr32 = adr; wdat32 = wd;
    ackPre = ack32;
    @(negedge clock);
    ackOk = ack32 && !ackPre;
    rd = rdat32;
    cyc32 = 0; stb32 = 0; we32 = 0;
    @(negedge clock);
    ackOk = ackOk && !ack32;
  endtask

  task automatic alignToTick();
    int guard = 0;
    while (((edgeCnt + 1) % Cc) != 0 && guard < 2 * Cc) begin
      @(negedge clock);
      guard++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    totalCnt++; if (ack64 !== 1'b0 || rdat64 !== 64'h0) $display("[TB] FAIL reset_bus64: ack=%b dat=%h required ack=0 dat=0", ack64, rdat64); else passCnt++;
    totalCnt++; if (mtime64 !== 64'h0) $display("[TB] FAIL reset_mtime: got %h required 0", mtime64); else passCnt++;
    repeat (3 * Cc) @(negedge clock);
    totalCnt++; if (mtime64 !== 64'd3) $display("[TB] FAIL idle_mtime64: got %h required 3", mtime64); else passCnt++;
    totalCnt++; if (mtime32 !== 64'd3) $display("[TB] FAIL idle_mtime32: got %h required 3", mtime32); else passCnt++;
    totalCnt++; if (msip64 !== 4'b0 || mtip64 !== 4'b0) $display("[TB] FAIL idle_irq64: msip=%b mtip=%b required 0/0", msip64, mtip64); else passCnt++;
    totalCnt++; if (msip32 !== 4'b0 || mtip32 !== 4'b0) $display("[TB] FAIL idle_irq32: msip=%b mtip=%b required 0/0", msip32, mtip32); else passCnt++;
    totalCnt++; if (cmp64 !== {256{1'b1}}) $display("[TB] FAIL reset_cmp64: got %h required all ones", cmp64); else passCnt++;
    totalCnt++; if (cmp32 !== {256{1'b1}}) $display("[TB] FAIL reset_cmp32: got %h required all ones", cmp32); else passCnt++;
  endtask

  task automatic test_mtimecmp32();
    logic [31:0] rd;
    logic ok;
    int guard = 0;
    bus32(1, 16'h400C, 32'h0, rd, ok);
    totalCnt++; if (!ok || rd !== 32'h0) $display("[TB] FAIL cmp32_hi0: ack=%b dat=%h required ack=1 dat=0", ok, rd); else passCnt++;
    bus32(1, 16'h4008, 32'h10, rd, ok);
    totalCnt++; if (!ok || rd !== 32'h10) $display("[TB] FAIL cmp32_lo: ack=%b dat=%h required ack=1 dat=10", ok, rd); else passCnt++;
    totalCnt++; if (cmp32[127:64] !== 64'h10) $display("[TB] FAIL cmp32_slice: got %h required 10", cmp32[127:64]); else passCnt++;
    while (edgeCnt < 4 * 16 - 1 && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    totalCnt++; if (edgeCnt != 63) $display("[TB] FAIL cmp32_wait: edge count %0d required 63", edgeCnt); else passCnt++;
    totalCnt++; if (mtime32 !== 64'd15 || mtip32 !== 4'b0) $display("[TB] FAIL cmp32_before: mtime=%h mtip=%b required 15/0000", mtime32, mtip32); else passCnt++;
    @(negedge clock);
    totalCnt++; if (mtime32 !== 64'd16 || mtip32 !== 4'b0010) $display("[TB] FAIL cmp32_rise: mtime=%h mtip=%b required 16/0010", mtime32, mtip32); else passCnt++;
    bus32(1, 16'h400C, 32'h1, rd, ok);
    totalCnt++; if (!ok || rd !== 32'h1) $display("[TB] FAIL cmp32_raise: ack=%b dat=%h required ack=1 dat=1", ok, rd); else passCnt++;
    totalCnt++; if (mtip32 !== 4'b0 || cmp32[127:64] !== 64'h1_0000_0010) $display("[TB] FAIL cmp32_fall: mtip=%b cmp=%h required 0000/100000010", mtip32, cmp32[127:64]); else passCnt++;
    // Low-half MTIME write on a tick edge carries into the untouched high half.
    alignToTick();
    bus32(1, 16'hBFF8, 32'hFFFF_FFFF, rd, ok);
    totalCnt++; if (!ok || rd !== 32'h0) $display("[TB] FAIL mtime32_carry_lo: ack=%b dat=%h required ack=1 dat=0", ok, rd); else passCnt++;
    bus32(0, 16'hBFFC, 32'h0, rd, ok);
    totalCnt++; if (!ok || rd !== 32'h1) $display("[TB] FAIL mtime32_carry_hi: ack=%b dat=%h required ack=1 dat=1", ok, rd); else passCnt++;
    totalCnt++; if (mtime32 !== 64'h1_0000_0000) $display("[TB] FAIL mtime32_value: got %h required 100000000", mtime32); else passCnt++;
  endtask

  task automatic test_msip();
    logic [63:0] rd;
    logic ok;
    bus64(1, 16'h0010, 64'h5, rd, ok);
    totalCnt++; if (!ok || rd !== 64'h1) $display("[TB] FAIL msip_write: ack=%b dat=%h required ack=1 dat=1", ok, rd); else passCnt++;
    totalCnt++; if (msip64 !== 4'b0100) $display("[TB] FAIL msip_lines: got %b required 0100", msip64); else passCnt++;
    bus64(0, 16'h0010, 64'h0, rd, ok);
    totalCnt++; if (!ok || rd !== 64'h1) $display("[TB] FAIL msip_read: ack=%b dat=%h required ack=1 dat=1", ok, rd); else passCnt++;
    bus64(1, 16'h0000, 64'h2, rd, ok);
    totalCnt++; if (rd !== 64'h0 || msip64 !== 4'b0100) $display("[TB] FAIL msip_bit1: dat=%h msip=%b required 0/0100", rd, msip64); else passCnt++;
  endtask

  task automatic test_mtime_wrap();
    logic [63:0] rd;
    logic ok;
    alignToTick();
    bus64(1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, rd, ok);
    totalCnt++; if (!ok || rd !== 64'h0) $display("[TB] FAIL mtime_wrap_data: ack=%b dat=%h required ack=1 dat=0", ok, rd); else passCnt++;
    totalCnt++; if (mtime64 !== 64'h0) $display("[TB] FAIL mtime_wrap_value: got %h required 0", mtime64); else passCnt++;
    bus64(1, 16'hBFF8, 64'h100, rd, ok);
    totalCnt++; if (rd !== 64'h100 || mtime64 !== 64'h100) $display("[TB] FAIL mtime_load: dat=%h mtime=%h required 100/100", rd, mtime64); else passCnt++;
    @(negedge clock);
    totalCnt++; if (mtime64 !== 64'h101) $display("[TB] FAIL mtime_prescale_kept: got %h required 101", mtime64); else passCnt++;
  endtask

  task automatic test_unmapped();
    logic [63:0] rd;
    logic ok;
    bus64(0, 16'h0040, 64'h0, rd, ok);
    totalCnt++; if (!ok || rd !== 64'h0) $display("[TB] FAIL unmapped_hart8: ack=%b dat=%h required ack=1 dat=0", ok, rd); else passCnt++;
    bus64(0, 16'h2000, 64'h0, rd, ok);
    totalCnt++; if (!ok || rd !== 64'h0) $display("[TB] FAIL unmapped_2000: ack=%b dat=%h required ack=1 dat=0", ok, rd); else passCnt++;
    bus64(1, 16'h2000, 64'hDEAD, rd, ok);
    bus64(1, 16'h4020, 64'h5, rd, ok);
    totalCnt++; if (msip64 !== 4'b0100 || cmp64 !== {256{1'b1}}) $display("[TB] FAIL unmapped_write: msip=%b cmp=%h required 0100/all ones", msip64, cmp64); else passCnt++;
  endtask

  task automatic test_sswi();
    logic [63:0] rd;
    logic ok;
    bus64(1, 16'hC018, 64'h1, rd, ok);
`ifdef CLINT_SSWI_EN
    totalCnt++; if (!ok || rd !== 64'h1 || ssip64 !== 4'b1000) $display("[TB] FAIL ssip_write: ack=%b dat=%h ssip=%b required 1/1/1000", ok, rd, ssip64); else passCnt++;
`else
    totalCnt++; if (!ok || rd !== 64'h0) $display("[TB] FAIL ssip_absent_write: ack=%b dat=%h required 1/0", ok, rd); else passCnt++;
`endif
    bus64(0, 16'hC018, 64'h0, rd, ok);
`ifdef CLINT_SSWI_EN
    totalCnt++; if (rd !== 64'h1) $display("[TB] FAIL ssip_read: got %h required 1", rd); else passCnt++;
`else
    totalCnt++; if (rd !== 64'h0 || msip64 !== 4'b0100) $display("[TB] FAIL ssip_absent_read: dat=%h msip=%b required 0/0100", rd, msip64); else passCnt++;
`endif
  endtask

  task automatic test_back_to_back();
    cyc64 = 1; stb64 = 1; we64 = 0; adr64 = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      totalCnt++;
      if (ack64 !== ((i % 2) == 0)) $display("[TB] FAIL b2b_ack%0d: got %b required %b", i, ack64, (i % 2) == 0);
      else if (ack64 && rdat64 !== 64'h1) $display("[TB] FAIL b2b_data%0d: got %h required 1", i, rdat64);
      else passCnt++;
    end
    cyc64 = 0; stb64 = 0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    cyc64 = 1; stb64 = 1; we64 = 1; adr64 = 16'h0000; wdat64 = 64'h1;
    @(posedge clock);
    #1;
    totalCnt++; if (ack64 !== 1'b1) $display("[TB] FAIL mid_ack_before: got %b required 1", ack64); else passCnt++;
    reset = 1;
    #1;
    totalCnt++; if (ack64 !== 1'b0 || rdat64 !== 64'h0 || msip64 !== 4'b0) $display("[TB] FAIL mid_reset: ack=%b dat=%h msip=%b required 0/0/0000", ack64, rdat64, msip64); else passCnt++;
    @(negedge clock);
    cyc64 = 0; stb64 = 0; we64 = 0;
    reset = 0;
    @(negedge clock);
    totalCnt++; if (ack64 !== 1'b0 || mtime64 !== 64'h0) $display("[TB] FAIL mid_after: ack=%b mtime=%h required 0/0", ack64, mtime64); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_mtimecmp32();
    test_msip();
    test_mtime_wrap();
    test_unmapped();
    test_sswi();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Multi-hart core-local interruptor; parametrised successor of the single-hart CSR memory block.
- Holds one shared 64-bit mtime, plus per-hart msip and mtimecmp.
- Drives per-hart machine software and timer interrupt lines to the cores.
- Wishbone slave on the peripheral bus; RV32 and RV64 data widths.

Parameters:
- DATA_SIZE, 32, bus data width; 32 or 64 only.
- ADDR_SIZE, 16, byte-address width of wb_if_s.
- NUM_HARTS, 4, harts served; 1..16.
- CLOCK_CYCLES, 30, clock cycles per mtime increment; must be >= 1.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-high.
- wb_if_s, wishbone_if slave modport, DATA_SIZE/ADDR_SIZE, register access.
- msip, output, NUM_HARTS, machine software interrupt pending, one bit per hart.
- mtip, output, NUM_HARTS, machine timer interrupt pending, one bit per hart.
- mtime, output, 64, current time.
- mtimecmp_o, output, 64*NUM_HARTS, packed compare values; hart h occupies [64h+:64].

Behaviour:
- Address map (byte offsets, all registers 8-byte stride):
  - MSIP(h) at 0x0000+8h.
  - MTIMECMP(h) at 0x4000+8h.
  - MTIME at 0xBFF8.
- RV32: addr[2] selects the high (1) or low (0) half. RV64: addr[2:0] ignored. sel and tgd ignored.
- MSIP: only bit 0 is implemented; other bits read 0.
- Unmapped addresses, or hart index >= NUM_HARTS: acked, read 0, write ignored.
- Handshake: a request is cyc&stb sampled at a posedge.
  - ack is registered and asserted exactly one cycle later, for one cycle.
  - A back-to-back request held high is served once per two cycles: ack forces idle in the acked cycle.
  - dat_i_p is valid while ack=1.
- Read data: register value at the request edge.
- Write data: dat_i_p returns the post-write register value, including any same-edge tick increment on MTIME.
- Tick: internal prescaler counts 0..CLOCK_CYCLES-1; tick=1 when count==CLOCK_CYCLES-1, then wraps to 0.
- mtime increments by 1 (mod 2^64) on each tick.
- MTIME write on a tick edge: mtime <= written value + 1.
  - RV32 partial write: the value is {new half, old other half}, then +1; carry may propagate into the unwritten half.
- Write without tick: plain load.
- A write to MTIME does not reset the prescaler.
- mtip[h] = (mtime >= mtimecmp[h]), unsigned 64-bit, combinational from registers; deasserts as soon as MTIMECMP is raised above mtime.
- msip[h] = MSIP(h) bit 0.
- Reset values: mtime=0, prescaler=0, msip=0, all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF (hence mtip=0), ack=0, dat_i_p=0.
- Reset asserted mid-transaction: the pending ack is dropped and no write takes effect.

Optional Feature:
- Macro: CLINT_SSWI_EN.
- Defined:
  - Adds output ssip [NUM_HARTS].
  - Adds registers SSIP(h) at 0xC000+8h, bit 0 only, same access rules as MSIP, reset 0.
  - ssip[h] = SSIP(h) bit 0.
- Undefined: port absent; 0xC000 region is unmapped (reads 0).

Decomposition:
- clint_pkg holds:
  - Region base constants MsipBase=0x0000, MtimecmpBase=0x4000, MtimeAddr=0xBFF8, SsipBase=0xC000.
  - HartStride=8.
  - typedef enum {RegMsip, RegMtimecmp, RegMtime, RegSsip, RegNone} clint_reg_e.
  - MtimecmpReset constant.
- One sub-module, clint_tick_gen: parametrised prescaler, outputs tick. Address decode and register file stay in clint_mh.

Test Plan:
- Reset, then idle 3*CLOCK_CYCLES clocks -> mtime=3, msip=0, mtip=0, every mtimecmp_o slice all-ones.
- RV64, NUM_HARTS=4: write 0x5 to 0x0010, then read it -> msip=4'b0100; read returns 0x1; ack one cycle after request both times.
- RV64: write 0xFFFF_FFFF_FFFF_FFFF to 0xBFF8 on a tick edge -> mtime wraps to 0, returned data 0.
- RV32: write 0x0000_0010 to 0x4008 (low half, hart 1) with high half 0, then idle until mtime=16 -> mtip[1] rises at the first cycle mtime=16; mtip[0,2,3] stay 0. Then write 0x1 to 0x400C (high half) -> mtip[1] falls next cycle.
- Read 0x0040 (hart 8 with NUM_HARTS=4) and 0x2000 -> ack=1, data 0. Write 0xDEAD to 0x2000 -> no register changes.
- CLINT_SSWI_EN defined: write 0x1 to 0xC018 -> ssip=4'b1000. Undefined: same write -> all state unchanged, read 0.
